div_issue_queue: RTL and testbench

Reservation station for the integer divide/remainder functional unit. It accepts decoded divide ops from dispatch with operands that are either ready or pending on a tag. It snoops the common data bus (CDB) to capture pending operands, then issues the oldest ready entry to the divider using its `queue_en`/operand/tag launch interface. It is the initiator side of the divider's launch protocol and paces issues to the divider's fixed 7-cycle occupancy.

---
 rtl/div_issue_queue_if.sv | 39 +++
 rtl/div_issue_queue.sv | 149 ++++++++++++++
 tb/tb_div_issue_queue.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_queue_if.sv
// Dispatch, CDB snoop and divider launch signals of the divide reservation station.
// The master side is the surrounding pipeline; the slave side is the queue itself.
interface div_issue_queue_if;
   logic        dispatch_en;
   logic [2:0]  dispatch_funct3;
   logic [5:0]  dispatch_rd_tag;
   logic        rs1_ready;
   logic        rs2_ready;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [5:0]  rs1_tag;
   logic [5:0]  rs2_tag;
   logic        cdb_valid;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        flush;
   logic        div_busy;
   logic        queue_full;
   logic        queue_en;
   logic [31:0] div_op1;
   logic [31:0] div_op2;
   logic [2:0]  div_funct3;
   logic [5:0]  div_tag;
   logic        div_tag_valid;

   modport master (
      output dispatch_en, dispatch_funct3, dispatch_rd_tag,
             rs1_ready, rs2_ready, rs1_data, rs2_data, rs1_tag, rs2_tag,
             cdb_valid, cdb_tag, cdb_data, flush, div_busy,
      input  queue_full, queue_en, div_op1, div_op2, div_funct3, div_tag, div_tag_valid
   );

   modport slave (
      input  dispatch_en, dispatch_funct3, dispatch_rd_tag,
             rs1_ready, rs2_ready, rs1_data, rs2_data, rs1_tag, rs2_tag,
             cdb_valid, cdb_tag, cdb_data, flush, div_busy,
      output queue_full, queue_en, div_op1, div_op2, div_funct3, div_tag, div_tag_valid
   );
endinterface

// File: rtl/div_issue_queue.sv
// Age-ordered reservation station for the divide unit: captures operands off the CDB,
// issues the oldest ready entry and paces launches to the divider's 7-cycle occupancy.
module div_issue_queue #(
   parameter int DEPTH = 4
) (
   input logic              clk,
   input logic              rst,
   div_issue_queue_if.slave bus
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic        valid;
      logic [2:0]  funct3;
      logic [5:0]  rd_tag;
      logic        rs1_ready;
      logic [5:0]  rs1_tag;
      logic [31:0] rs1_data;
      logic        rs2_ready;
      logic [5:0]  rs2_tag;
      logic [31:0] rs2_data;
   } entry_t;

   entry_t        q     [DEPTH];
   entry_t        q_snp [DEPTH];
   entry_t        q_nxt [DEPTH];
   entry_t        new_entry;
   logic [2:0]    holdoff;
   logic [2:0]    holdoff_nxt;
   logic [CW-1:0] count;
   logic [CW-1:0] wr_idx;
   logic [IW-1:0] sel_idx;
   logic          sel_found;
   logic          issue;
   logic          accept;
   logic          full;

   // Entries stay packed from index 0, so occupancy is just the number of valid bits.
   always_comb begin
      count = '0;
      for (int i = 0; i < DEPTH; i++)
         if (q[i].valid) count = count + CW'(1);
   end

   assign full = (count == CW'(DEPTH));

   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (q[i].valid && q[i].rs1_ready && q[i].rs2_ready) begin
            sel_idx   = IW'(i);
            sel_found = 1'b1;
         end
      end
   end

   assign issue  = sel_found && (holdoff == 3'd0) && !bus.div_busy && !bus.flush;
   assign accept = bus.dispatch_en && !full && !bus.flush;
   assign wr_idx = issue ? (count - CW'(1)) : count;

   always_comb begin
      new_entry           = '0;
      new_entry.valid     = 1'b1;
      new_entry.funct3    = bus.dispatch_funct3;
      new_entry.rd_tag    = bus.dispatch_rd_tag;
      new_entry.rs1_tag   = bus.rs1_tag;
      new_entry.rs2_tag   = bus.rs2_tag;
      new_entry.rs1_ready = bus.rs1_ready;
      new_entry.rs2_ready = bus.rs2_ready;
      new_entry.rs1_data  = bus.rs1_data;
      new_entry.rs2_data  = bus.rs2_data;
      if (!bus.rs1_ready && bus.cdb_valid && (bus.cdb_tag == bus.rs1_tag)) begin
         new_entry.rs1_ready = 1'b1;
         new_entry.rs1_data  = bus.cdb_data;
      end
      if (!bus.rs2_ready && bus.cdb_valid && (bus.cdb_tag == bus.rs2_tag)) begin
         new_entry.rs2_ready = 1'b1;
         new_entry.rs2_data  = bus.cdb_data;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         q_snp[i] = q[i];
         if (q[i].valid && !q[i].rs1_ready && bus.cdb_valid && (bus.cdb_tag == q[i].rs1_tag)) begin
            q_snp[i].rs1_ready = 1'b1;
            q_snp[i].rs1_data  = bus.cdb_data;
         end
         if (q[i].valid && !q[i].rs2_ready && bus.cdb_valid && (bus.cdb_tag == q[i].rs2_tag)) begin
            q_snp[i].rs2_ready = 1'b1;
            q_snp[i].rs2_data  = bus.cdb_data;
         end
      end
   end

   // Removal shifts everything above the issued slot down; dispatch lands just past the survivors.
   always_comb begin
      for (int i = 0; i < DEPTH - 1; i++)
         q_nxt[i] = (issue && (i >= int'(sel_idx))) ? q_snp[i + 1] : q_snp[i];
      q_nxt[DEPTH - 1] = issue ? '0 : q_snp[DEPTH - 1];
      if (accept) begin
         for (int i = 0; i < DEPTH; i++)
            if (CW'(i) == wr_idx) q_nxt[i] = new_entry;
      end
      if (bus.flush) begin
         for (int i = 0; i < DEPTH; i++) q_nxt[i] = '0;
      end
   end

   // Holdoff survives flush: an already launched divide keeps the divider occupied.
   always_comb begin
      holdoff_nxt = holdoff;
      if (issue)
         holdoff_nxt = 3'd6;
      else if (holdoff != 3'd0)
         holdoff_nxt = holdoff - 3'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
         holdoff <= 3'd0;
      end else begin
         q       <= q_nxt;
         holdoff <= holdoff_nxt;
      end
   end

   always_comb begin
      bus.queue_en      = 1'b0;
      bus.div_tag_valid = 1'b0;
      bus.div_op1       = '0;
      bus.div_op2       = '0;
      bus.div_funct3    = '0;
      bus.div_tag       = '0;
      if (issue) begin
         bus.queue_en      = 1'b1;
         bus.div_tag_valid = 1'b1;
         bus.div_op1       = q[sel_idx].rs1_data;
         bus.div_op2       = q[sel_idx].rs2_data;
         bus.div_funct3    = q[sel_idx].funct3;
         bus.div_tag       = q[sel_idx].rd_tag;
      end
   end

   assign bus.queue_full = full;
endmodule

// File: tb/tb_div_issue_queue.sv
// Directed bench for div_issue_queue: a per-cycle vector table plus hand sequences
// for full/ordering, flush with pending holdoff, and asynchronous reset.
module tb_div_issue_queue;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   div_issue_queue_if bus ();

   div_issue_queue #(.DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        disp;
      logic [2:0]  f3;
      logic [5:0]  rd;
      logic        r1;
      logic [31:0] d1;
      logic [5:0]  t1;
      logic        r2;
      logic [31:0] d2;
      logic [5:0]  t2;
      logic        cv;
      logic [5:0]  ct;
      logic [31:0] cd;
      logic        busy;
      logic        e_en;
      logic [31:0] e_op1;
      logic [31:0] e_op2;
      logic [5:0]  e_tag;
      logic [2:0]  e_f3;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic v(input logic disp, input logic [2:0] f3, input logic [5:0] rd,
                    input logic r1, input logic [31:0] d1, input logic [5:0] t1,
                    input logic r2, input logic [31:0] d2, input logic [5:0] t2,
                    input logic cv, input logic [5:0] ct, input logic [31:0] cd,
                    input logic busy, input logic e_en, input logic [31:0] e_op1,
                    input logic [31:0] e_op2, input logic [5:0] e_tag, input logic [2:0] e_f3);
      vec_t x;
      x = '{disp, f3, rd, r1, d1, t1, r2, d2, t2, cv, ct, cd, busy, e_en, e_op1, e_op2, e_tag, e_f3};
      vecs.push_back(x);
   endtask

   task automatic idle(input int n, input logic busy);
      for (int i = 0; i < n; i++) v(0,0,0, 0,0,0, 0,0,0, 0,0,0, busy, 0,0,0,0,0);
   endtask

   task automatic iss(input logic [31:0] o1, input logic [31:0] o2, input logic [5:0] tag, input logic [2:0] f3);
      v(0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 1,o1,o2,tag,f3);
   endtask

   task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
      v(0,0,0, 0,0,0, 0,0,0, 1,tag,data, 0, 0,0,0,0,0);
   endtask

   task automatic set_idle();
      bus.dispatch_en     = 1'b0;
      bus.dispatch_funct3 = '0;
      bus.dispatch_rd_tag = '0;
      bus.rs1_ready       = 1'b0;
      bus.rs2_ready       = 1'b0;
      bus.rs1_data        = '0;
      bus.rs2_data        = '0;
      bus.rs1_tag         = '0;
      bus.rs2_tag         = '0;
      bus.cdb_valid       = 1'b0;
      bus.cdb_tag         = '0;
      bus.cdb_data        = '0;
      bus.flush           = 1'b0;
   endtask

   task automatic dispatch_rdy(input logic [2:0] f3, input logic [5:0] tag,
                               input logic [31:0] a, input logic [31:0] b);
      bus.dispatch_en     = 1'b1;
      bus.dispatch_funct3 = f3;
      bus.dispatch_rd_tag = tag;
      bus.rs1_ready       = 1'b1;
      bus.rs2_ready       = 1'b1;
      bus.rs1_data        = a;
      bus.rs2_data        = b;
   endtask

   task automatic do_reset();
      @(negedge clk);
      set_idle();
      bus.div_busy = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // From the cycle after an issue: gap-1 silent cycles, then an issue of the given entry.
   task automatic expect_issue_after(input int gap, input logic [5:0] tag, input logic [31:0] op1);
      for (int j = 1; j < gap; j++) begin
         @(negedge clk);
         set_idle();
         #2;
         chk($sformatf("gap_en tag%0d c%0d", tag, j), bus.queue_en, 0);
         chk($sformatf("gap_full tag%0d c%0d", tag, j), bus.queue_full, 0);
      end
      @(negedge clk);
      set_idle();
      #2;
      chk($sformatf("issue_en tag%0d", tag), bus.queue_en, 1);
      chk($sformatf("issue_tag tag%0d", tag), bus.div_tag, tag);
      chk($sformatf("issue_op1 tag%0d", tag), bus.div_op1, op1);
   endtask

   initial begin
      rst = 1'b1;
      set_idle();
      bus.div_busy = 1'b0;

      // Back-to-back ready ops: issues at t=1 and t=8.
      v(1,5,5, 1,100,0, 1,7,0, 0,0,0, 0, 0,0,0,0,0);
      v(1,6,6, 1,50,0,  1,3,0, 0,0,0, 0, 1,100,7,5,5);
      idle(5, 1);
      idle(1, 0);
      iss(50,3,6,6);
      idle(6, 0);
      // Older entry waiting on tag 9 is bypassed by a younger ready one.
      v(1,4,10, 0,0,9,  1,8,0, 0,0,0, 0, 0,0,0,0,0);
      v(1,5,11, 1,20,0, 1,4,0, 0,0,0, 0, 0,0,0,0,0);
      iss(20,4,11,5);
      cdb(9, 32'h40);
      idle(5, 0);
      iss(32'h40,8,10,4);
      idle(6, 0);
      // Dispatch-cycle forwarding of rs2 from the CDB.
      v(1,7,12, 1,77,0, 0,0,3, 1,3,2, 0, 0,0,0,0,0);
      iss(77,2,12,7);
      idle(6, 0);
      // Capture with holdoff already clear: eligible the cycle after the broadcast.
      v(1,5,13, 0,0,20, 1,9,0, 0,0,0, 0, 0,0,0,0,0);
      cdb(20, 32'h99);
      iss(32'h99,9,13,5);
      idle(6, 0);
      // Both operands captured by one broadcast, then held off by div_busy for a cycle.
      v(1,4,14, 0,0,21, 0,0,21, 0,0,0, 0, 0,0,0,0,0);
      cdb(21, 7);
      idle(1, 1);
      iss(7,7,14,4);
      idle(2, 0);

      @(negedge clk);
      @(negedge clk);
      #2;
      chk("reset queue_en", bus.queue_en, 0);
      chk("reset tag_valid", bus.div_tag_valid, 0);
      chk("reset full", bus.queue_full, 0);
      chk("reset op1", bus.div_op1, 0);
      chk("reset op2", bus.div_op2, 0);
      chk("reset tag", bus.div_tag, 0);
      chk("reset funct3", bus.div_funct3, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         bus.dispatch_en     = vecs[i].disp;
         bus.dispatch_funct3 = vecs[i].f3;
         bus.dispatch_rd_tag = vecs[i].rd;
         bus.rs1_ready       = vecs[i].r1;
         bus.rs1_data        = vecs[i].d1;
         bus.rs1_tag         = vecs[i].t1;
         bus.rs2_ready       = vecs[i].r2;
         bus.rs2_data        = vecs[i].d2;
         bus.rs2_tag         = vecs[i].t2;
         bus.cdb_valid       = vecs[i].cv;
         bus.cdb_tag         = vecs[i].ct;
         bus.cdb_data        = vecs[i].cd;
         bus.flush           = 1'b0;
         bus.div_busy        = vecs[i].busy;
         #2;
         chk($sformatf("vec%0d queue_en", i), bus.queue_en, vecs[i].e_en);
         chk($sformatf("vec%0d tag_valid", i), bus.div_tag_valid, vecs[i].e_en);
         chk($sformatf("vec%0d op1", i), bus.div_op1, vecs[i].e_op1);
         chk($sformatf("vec%0d op2", i), bus.div_op2, vecs[i].e_op2);
         chk($sformatf("vec%0d tag", i), bus.div_tag, vecs[i].e_tag);
         chk($sformatf("vec%0d funct3", i), bus.div_funct3, vecs[i].e_f3);
         chk($sformatf("vec%0d full", i), bus.queue_full, 0);
      end

      // Fill, drop extras (including one offered in the issue cycle), keep order after shifts.
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         set_idle();
         bus.div_busy = 1'b1;
         dispatch_rdy(3'd5, 6'(k), 32'(10 * k), 32'(k));
         #2;
         chk($sformatf("fill full k%0d", k), bus.queue_full, 0);
      end
      @(negedge clk);
      set_idle();
      dispatch_rdy(3'd5, 6'd5, 32'd50, 32'd5);
      #2;
      chk("full asserted", bus.queue_full, 1);
      chk("full no issue while busy", bus.queue_en, 0);
      @(negedge clk);
      set_idle();
      bus.div_busy = 1'b0;
      dispatch_rdy(3'd5, 6'd6, 32'd60, 32'd6);
      #2;
      chk("full issue en", bus.queue_en, 1);
      chk("full issue tag", bus.div_tag, 1);
      chk("full issue op1", bus.div_op1, 10);
      chk("full still full", bus.queue_full, 1);
      expect_issue_after(7, 6'd2, 32'd20);
      expect_issue_after(7, 6'd3, 32'd30);
      expect_issue_after(7, 6'd4, 32'd40);
      for (int j = 0; j < 14; j++) begin
         @(negedge clk);
         set_idle();
         #2;
         chk($sformatf("dropped never issue c%0d", j), bus.queue_en, 0);
      end

      // Flush with three entries valid while holdoff is 4; holdoff must keep counting.
      do_reset();
      @(negedge clk);
      set_idle();
      dispatch_rdy(3'd5, 6'd30, 32'd1, 32'd1);
      #2;
      chk("flush pre none", bus.queue_en, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         set_idle();
         dispatch_rdy(3'd4, 6'(31 + k), 32'(90 + k), 32'd3);
         #2;
         chk($sformatf("flush load en c%0d", k), bus.queue_en, (k == 0) ? 1 : 0);
      end
      @(negedge clk);
      set_idle();
      bus.flush = 1'b1;
      dispatch_rdy(3'd4, 6'd34, 32'd70, 32'd7);
      #2;
      chk("flush cycle no issue", bus.queue_en, 0);
      @(negedge clk);
      set_idle();
      dispatch_rdy(3'd5, 6'd40, 32'd4, 32'd2);
      #2;
      chk("post flush none", bus.queue_en, 0);
      chk("post flush full", bus.queue_full, 0);
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         set_idle();
         #2;
         chk($sformatf("flush holdoff kept c%0d", j), bus.queue_en, 0);
      end
      @(negedge clk);
      set_idle();
      #2;
      chk("post flush issue en", bus.queue_en, 1);
      chk("post flush issue tag", bus.div_tag, 40);
      chk("post flush issue op1", bus.div_op1, 4);

      // Asynchronous reset in the middle of a cycle with a full queue.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         set_idle();
         bus.div_busy = 1'b1;
         dispatch_rdy(3'd7, 6'(50 + k), 32'd9, 32'd9);
      end
      @(negedge clk);
      set_idle();
      #2;
      chk("pre async rst full", bus.queue_full, 1);
      bus.div_busy = 1'b0;
      rst = 1'b1;
      #1;
      chk("async rst full", bus.queue_full, 0);
      chk("async rst en", bus.queue_en, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         #2;
         chk($sformatf("after rst empty c%0d", j), bus.queue_en, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
